demux_stream_1xn: RTL
=====================

Name: demux_stream_1xn

Overview:
- Parametrised 1-to-N packet demultiplexer with a registered valid/ready stream interface; successor to the combinational 1x8 demux.
- Routes every beat of a packet to the output lane selected on the packet's first beat and holds that route until the last beat.
- Discards and counts packets whose select is out of range.
- Sits between a single producer and N consumer lanes, for example a bus fabric or per-channel FIFOs.

Parameters:
- DATA_W, 8, width of one data beat.
- N_OUT, 8, number of output lanes; must be at least 2.
- SEL_W, $clog2(N_OUT), width of in_sel; may be overridden wider than needed.
- CNT_W, 16, width of the dropped-packet counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  DATA_W  beat payload.
- in_last  input  1  marks the final beat of a packet.
- in_sel  input  SEL_W  destination lane; sampled only on the first beat of a packet.
- out_valid  output  N_OUT  one-hot per-lane valid.
- out_ready  input  N_OUT  per-lane ready.
- out_data  output  DATA_W  payload, broadcast to all lanes.
- out_last  output  1  last flag, broadcast to all lanes.
- drop_cnt  output  CNT_W  number of dropped packets; saturates at all-ones.
- busy  output  1  high while in the LOCK or DROP state.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE; hold_valid=0.
  - out_valid=0, out_data=0, out_last=0, drop_cnt=0, busy=0; in_ready=0 while rst is high.
  - A packet in flight at reset is lost; no partial beats appear after reset releases.
- Holding register: one stage holding data, last, dest and hold_valid.
  - out_valid = hold_valid ? (1 << dest) : 0.
  - Output handshake: hold_valid && out_ready[dest].
  - out_ready bits of unselected lanes are ignored.
- Latency and throughput:
  - An accepted beat appears on out_* in the next cycle.
  - Full throughput: in_ready = !hold_valid || out_ready[dest] when the beat is routed (IDLE with legal in_sel, or LOCK).
  - In DROP, or in IDLE with an illegal in_sel, in_ready=1.
- FSM states:
  - IDLE, on an in_valid && in_ready beat:
    - If in_sel < N_OUT: the beat is loaded with dest=in_sel and lock_sel=in_sel. Go to LOCK if !in_last, otherwise stay in IDLE.
    - If in_sel >= N_OUT: the beat is discarded and drop_cnt increments (saturating). Go to DROP if !in_last, otherwise stay in IDLE.
  - LOCK: every accepted beat loads with dest=lock_sel; in_sel is ignored. An accepted beat with in_last goes to IDLE.
  - DROP: all beats are accepted and discarded. An accepted beat with in_last goes to IDLE; drop_cnt does not increment again.
- Simultaneous load and drain:
  - A register draining while a new beat loads in the same cycle replaces the contents with no bubble.
  - Consecutive packets to different lanes also run back-to-back: the new dest takes effect with the loaded beat.
- Backpressure and stability:
  - While hold_valid && !out_ready[dest], out_data, out_last and out_valid stay stable.
  - in_data, in_last and in_sel changes are ignored until in_ready.
- in_valid low: no state change, including mid-packet; a packet may contain idle cycles.
- drop_cnt: holds at 2^CNT_W-1 once reached; never wraps.
- Single-beat packets (in_last on the first beat) never enter LOCK or DROP.

Decomposition:
- Shared package demux_pkg holds:
  - state enum (IDLE, LOCK, DROP);
  - sel_legal(sel, n) function;
  - SAT_INC helper for saturating counters.
- One natural sub-module: stream_reg_slice, the single-entry valid/ready holding register. It is parametrised on payload width (DATA_W+1+SEL_W) and is reusable in later stream blocks.
- The FSM, lane decode and counter stay in the top level.

Test Plan:
- Reset check: assert rst mid-cycle while idle -> all outputs 0 immediately; after release, in_ready=1 and drop_cnt=0.
- Routing, all lanes: N_OUT=8, send single-beat packets data=8'hA0+k with sel=k for k=0..7, all out_ready=1 -> each appears one cycle later with out_valid=8'h01<<k and out_last=1. Throughput is one beat per cycle.
- Packet lock: 4-beat packet, sel=3 on beat 0 and sel changed to 5 on beats 1-3 -> all 4 beats on lane 3; busy=1 from the cycle after beat 0 until beat 3 is accepted.
- Backpressure: hold out_ready[2]=0 for 5 cycles with a beat to lane 2 -> out_valid=8'h04 and data stable; in_ready=0. Raising out_ready[2] drains the beat; the next beat follows with no bubble.
- Illegal select and counter saturation:
  - N_OUT=6, SEL_W=3: a 3-beat packet with sel=7 -> in_ready=1 throughout, no out_valid, drop_cnt=1.
  - CNT_W=2 with 5 illegal packets -> drop_cnt stays at 3.
- Reset mid-packet: assert rst after beat 2 of a 6-beat packet to lane 1 -> out_valid=0 and busy=0 at once. After release, a new packet with sel=4 routes to lane 4.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared types and helpers for the stream demultiplexer family.
//   state_e   - packet FSM states (IDLE, LOCK, DROP)
//   sel_legal - true when a lane select addresses an existing lane
//   SAT_INC   - saturating increment for counters up to 32 bits wide
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    DROP = 2'd2
  } state_e;

  function automatic logic sel_legal(input logic [31:0] sel, input int unsigned n);
    return sel < n;
  endfunction

  function automatic logic [31:0] SAT_INC(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// stream_reg_slice: single-entry valid/ready holding register, full throughput.
//   clk_i, rst_i          clock, asynchronous active-high reset
//   s_valid_i/s_ready_o   upstream handshake, s_data_i payload
//   m_valid_o/m_ready_i   downstream handshake, m_data_o payload
// A drain and a load in the same cycle replace the entry with no bubble.
module stream_reg_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign s_ready_o = !valid_q || m_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (s_valid_i && s_ready_o) begin
      valid_d = 1'b1;
      data_d  = s_data_i;
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;

endmodule

// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: 1-to-N packet demultiplexer with registered valid/ready.
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    producer handshake; in_data, in_last, in_sel beat fields
//   out_valid/out_ready  one-hot per-lane handshake; out_data, out_last broadcast
//   drop_cnt             saturating count of packets with an out-of-range select
//   busy                 high while mid-packet (LOCK or DROP)
// The route is chosen on the first beat and held until the last beat.
module demux_stream_1xn
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_OUT  = 8,
  parameter int unsigned SEL_W  = $clog2(N_OUT),
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);

  localparam int unsigned      PW      = DATA_W + 1 + SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   lock_q, lock_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic               sel_ok, route, accept;
  logic               s_valid, s_ready;
  logic [SEL_W-1:0]   load_dest;
  logic [PW-1:0]      s_payload, m_payload;
  logic               hold_valid, hold_last, lane_ready;
  logic [SEL_W-1:0]   hold_dest;
  logic [DATA_W-1:0]  hold_data;

  assign sel_ok = sel_legal(32'(in_sel), N_OUT);

  // Beats are routed in LOCK, or on a legal first beat; everything else is
  // swallowed, so in_ready only waits on the holding register when routing.
  assign route     = (state_q == LOCK) || ((state_q == IDLE) && sel_ok);
  assign in_ready  = !rst && (route ? s_ready : 1'b1);
  assign accept    = in_valid && in_ready;
  assign s_valid   = in_valid && route && !rst;
  assign load_dest = (state_q == LOCK) ? lock_q : in_sel;
  assign s_payload = {in_last, load_dest, in_data};

  stream_reg_slice #(
    .W(PW)
  ) u_hold (
    .clk_i    (clk),
    .rst_i    (rst),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .s_data_i (s_payload),
    .m_valid_o(hold_valid),
    .m_ready_i(lane_ready),
    .m_data_o (m_payload)
  );

  assign {hold_last, hold_dest, hold_data} = m_payload;

  always_comb begin
    out_valid = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      out_valid[i] = hold_valid && (hold_dest == SEL_W'(i));
    end
  end

  // Only the selected lane's ready can drain the register.
  assign lane_ready = |(out_valid & out_ready);

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_ok) begin
            lock_d = in_sel;
            if (!in_last) state_d = LOCK;
          end else begin
            drop_d = CNT_W'(SAT_INC(32'(drop_q), 32'(CNT_MAX)));
            if (!in_last) state_d = DROP;
          end
        end
      end
      LOCK, DROP: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data = hold_data;
  assign out_last = hold_last;
  assign drop_cnt = drop_q;
  assign busy     = (state_q != IDLE);

endmodule
